// File: rtl/aliens_bus_initiator_if.sv
// Request/response, config and address-bus signals of the Aliens bus initiator.
// bus_wait is present only when ALIENS_BUS_WAIT_EN is defined.
interface aliens_bus_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        cfg_we;
  logic        cfg_bk4;
  logic        cfg_woco;
  logic        cfg_init;
  logic        AS;
  logic        RW;
  logic [15:0] MA;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        BK4;
  logic        WOCO;
  logic        INIT;
`ifdef ALIENS_BUS_WAIT_EN
  logic        bus_wait;
`endif

  modport master (
    input  req_valid, req_addr, req_we, req_wdata,
    input  cfg_we, cfg_bk4, cfg_woco, cfg_init,
    input  DI,
`ifdef ALIENS_BUS_WAIT_EN
    input  bus_wait,
`endif
    output req_ready, rsp_valid, rsp_rdata,
    output AS, RW, MA, DO, BK4, WOCO, INIT
  );

  modport slave (
    output req_valid, req_addr, req_we, req_wdata,
    output cfg_we, cfg_bk4, cfg_woco, cfg_init,
    output DI,
`ifdef ALIENS_BUS_WAIT_EN
    output bus_wait,
`endif
    input  req_ready, rsp_valid, rsp_rdata,
    input  AS, RW, MA, DO, BK4, WOCO, INIT
  );
endinterface

// File: rtl/aliens_bus_initiator.sv
// Aliens bus-cycle initiator: turns requests into SETUP/STROBE/HOLD cycles on AS/RW/MA/DO
// and drives BK4/WOCO/INIT. Define ALIENS_BUS_WAIT_EN to add bus_wait strobe extension.
module aliens_bus_initiator #(
  parameter int unsigned AS_CYCLES = 2
`ifdef ALIENS_BUS_WAIT_EN
  , parameter int unsigned MAX_WAIT = 15
`endif
) (
  input logic                    i_clk,
  input logic                    i_reset,
  aliens_bus_initiator_if.master bus
);
  // state  | meaning
  // IDLE   | ready for a request; cfg_we applies directly
  // SETUP  | MA/RW/DO driven, AS high, one cycle
  // STROBE | AS low for AS_CYCLES cycles (plus wait extensions)
  // HOLD   | AS high, MA/RW/DO still held, one cycle
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam logic [3:0] AS_LOAD = 4'(AS_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_as;
  logic        w_req_ready;
  logic        w_accept;
  logic        w_extend;
  logic        w_forced;
  logic        w_strobe_end;
  logic [3:0]  r_as_cnt;
  logic [15:0] r_ma;
  logic        r_rw;
  logic [7:0]  r_do;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic        r_bk4;
  logic        r_woco;
  logic        r_init;
  logic        r_cfg_pend;
  logic [2:0]  r_cfg_pend_val;

  assign w_req_ready  = (r_state == S_IDLE) && !i_reset;
  assign w_accept     = bus.req_valid && w_req_ready;
  assign w_strobe_end = (r_state == S_STROBE) && (r_as_cnt == 4'd0) && !w_extend;

`ifdef ALIENS_BUS_WAIT_EN
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
  logic [7:0] r_wait_cnt;
  logic       w_at_max;

  assign w_at_max = (r_wait_cnt == WAIT_MAX);
  assign w_extend = (r_state == S_STROBE) && (r_as_cnt == 4'd0) && bus.bus_wait && !w_at_max;
  // Wait budget exhausted while the target still stalls: finish with poisoned read data.
  assign w_forced = bus.bus_wait && w_at_max;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == S_SETUP) begin
      r_wait_cnt <= 8'd0;
    end else if (w_extend) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`else
  assign w_extend = 1'b0;
  assign w_forced = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_as        = 1'b1;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: begin
        w_as = 1'b0;
        if (w_strobe_end) w_state_nxt = S_HOLD;
      end
      S_HOLD:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_as_cnt       <= 4'd0;
      r_ma           <= 16'd0;
      r_rw           <= 1'b1;
      r_do           <= 8'd0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= 8'd0;
      r_bk4          <= 1'b0;
      r_woco         <= 1'b0;
      r_init         <= 1'b1;
      r_cfg_pend     <= 1'b0;
      r_cfg_pend_val <= 3'd0;
    end else begin
      r_rsp_valid <= (r_state == S_HOLD);

      if (w_accept) begin
        r_ma <= bus.req_addr;
        r_rw <= !bus.req_we;
        r_do <= bus.req_wdata;
      end else if (r_state == S_HOLD) begin
        r_rw <= 1'b1;
      end

      if (r_state == S_SETUP) begin
        r_as_cnt <= AS_LOAD;
      end else if ((r_state == S_STROBE) && (r_as_cnt != 4'd0)) begin
        r_as_cnt <= r_as_cnt - 4'd1;
      end

      if (w_strobe_end) begin
        r_rsp_rdata <= !r_rw ? 8'h00 : (w_forced ? 8'hFF : bus.DI);
      end

      // Config may only move while no bus cycle is in flight; otherwise it waits for HOLD->IDLE.
      if (r_state == S_IDLE) begin
        if (bus.cfg_we) {r_bk4, r_woco, r_init} <= {bus.cfg_bk4, bus.cfg_woco, bus.cfg_init};
      end else if (r_state == S_HOLD) begin
        if (bus.cfg_we) begin
          {r_bk4, r_woco, r_init} <= {bus.cfg_bk4, bus.cfg_woco, bus.cfg_init};
        end else if (r_cfg_pend) begin
          {r_bk4, r_woco, r_init} <= r_cfg_pend_val;
        end
        r_cfg_pend <= 1'b0;
      end else if (bus.cfg_we) begin
        r_cfg_pend     <= 1'b1;
        r_cfg_pend_val <= {bus.cfg_bk4, bus.cfg_woco, bus.cfg_init};
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.AS        = w_as;
  assign bus.RW        = r_rw;
  assign bus.MA        = r_ma;
  assign bus.DO        = r_do;
  assign bus.BK4       = r_bk4;
  assign bus.WOCO      = r_woco;
  assign bus.INIT      = r_init;
endmodule
